// File: rtl/arbitro_sumador_pkg.sv
// Shared widths, idx tag layout and small helpers for the arbiter/adder front end.
// Optional feature: SUMARB_ROUNDROBIN_EN selects round-robin instead of fixed priority.
package arbitro_sumador_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned DATA_W       = 4;
  localparam int unsigned ID_W         = 2;
  localparam int unsigned ADDER_LAT    = 2;
  localparam int unsigned BUS_W        = NUM_REQ * DATA_W;

  localparam int unsigned IDX_W        = 4;
  localparam int unsigned IDX_VLD_BIT  = 3;
  localparam int unsigned IDX_RSVD_BIT = 2;
  localparam int unsigned IDX_ID_LSB   = 0;

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned OPS_MAX      = 255;

  // Tag sent to the adder: {valid, 0, id}
  function automatic logic [IDX_W-1:0] make_idx(input logic [ID_W-1:0] id);
    logic [IDX_W-1:0] t;
    t                         = '0;
    t[IDX_VLD_BIT]            = 1'b1;
    t[IDX_ID_LSB +: ID_W]     = id;
    return t;
  endfunction

  function automatic logic [DATA_W-1:0] get_slot(input logic [BUS_W-1:0] packed_ops,
                                                 input logic [ID_W-1:0]  id);
    return packed_ops[DATA_W*int'(id) +: DATA_W];
  endfunction

endpackage

// File: rtl/arbitro_sumador_if.sv
// Requester, adder and response signals of arbitro_sumador.
// slave = the arbiter block, master = requesters plus the external adder.
interface arbitro_sumador_if;
  import arbitro_sumador_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [BUS_W-1:0]   req_dataA;
  logic [BUS_W-1:0]   req_dataB;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  dataA;
  logic [DATA_W-1:0]  dataB;
  logic [IDX_W-1:0]   idx_dd;
  logic [DATA_W-1:0]  sum30_dd;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [DATA_W-1:0]  rsp_sum;
  logic [CNT_W-1:0]   ops_done;

  modport slave (
    input  req, req_dataA, req_dataB, idx_dd, sum30_dd,
    output gnt, idx, dataA, dataB, rsp_valid, rsp_id, rsp_sum, ops_done
  );

  modport master (
    output req, req_dataA, req_dataB, idx_dd, sum30_dd,
    input  gnt, idx, dataA, dataB, rsp_valid, rsp_id, rsp_sum, ops_done
  );
endinterface

// File: rtl/arbitro_sumador_rr_arbitro4.sv
// rr_arbitro4: picks one eligible requester per cycle, combinational one-hot grant.
// SUMARB_ROUNDROBIN_EN: rotate priority from last+1; otherwise fixed, requester 0 highest.
module rr_arbitro4
  import arbitro_sumador_pkg::*;
(
`ifdef SUMARB_ROUNDROBIN_EN
  input  logic               clk,
  input  logic               rst_n,
`endif
  input  logic [NUM_REQ-1:0] elig_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [ID_W-1:0]    gnt_id_c_o,
  output logic               gnt_vld_c_o
);

`ifdef SUMARB_ROUNDROBIN_EN
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;
  logic [ID_W-1:0] cand_c;

  // Search starts just after the last winner, wrapping modulo NUM_REQ
  always_comb begin
    gnt_c_o     = '0;
    gnt_id_c_o  = '0;
    gnt_vld_c_o = 1'b0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = last_q + ID_W'(k + 1);
      if (!gnt_vld_c_o && elig_i[cand_c]) begin
        gnt_vld_c_o = 1'b1;
        gnt_id_c_o  = cand_c;
      end
    end
    gnt_c_o[gnt_id_c_o] = gnt_vld_c_o;
    last_d = gnt_vld_c_o ? gnt_id_c_o : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= ID_W'(NUM_REQ - 1);
    else        last_q <= last_d;
  end
`else
  // Scan high to low so the lowest eligible index wins
  always_comb begin
    gnt_c_o     = '0;
    gnt_id_c_o  = '0;
    gnt_vld_c_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_i[k]) begin
        gnt_vld_c_o = 1'b1;
        gnt_id_c_o  = ID_W'(k);
      end
    end
    gnt_c_o[gnt_id_c_o] = gnt_vld_c_o;
  end
`endif

endmodule

// File: rtl/arbitro_sumador.sv
// Arbitrates four requesters onto an external 2-stage adder and routes results back.
// SUMARB_ROUNDROBIN_EN switches the arbiter from fixed priority to round-robin.
module arbitro_sumador
  import arbitro_sumador_pkg::*;
(
  input  logic                clk,
  input  logic                reset_L,
  arbitro_sumador_if.slave    bus
);

  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_a_q, data_a_d;
  logic [DATA_W-1:0]  data_b_q, data_b_d;
  logic [CNT_W-1:0]   ops_q, ops_d;

  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] arb_gnt_c;
  logic [ID_W-1:0]    arb_id_c;
  logic               arb_vld_c;
  logic [NUM_REQ-1:0] ret_mask_c;
  logic [ID_W-1:0]    ret_id_c;
  logic               rsp_valid_c;
  logic               unused_rsvd_c;

  assign elig_c = bus.req & ~pending_q;

  rr_arbitro4 u_arb (
`ifdef SUMARB_ROUNDROBIN_EN
    .clk         (clk),
    .rst_n       (reset_L),
`endif
    .elig_i      (elig_c),
    .gnt_c_o     (arb_gnt_c),
    .gnt_id_c_o  (arb_id_c),
    .gnt_vld_c_o (arb_vld_c)
  );

  // Returns for flushed (non-pending) ids are dropped here
  assign ret_id_c      = bus.idx_dd[IDX_ID_LSB +: ID_W];
  assign rsp_valid_c   = bus.idx_dd[IDX_VLD_BIT] & pending_q[ret_id_c];
  assign unused_rsvd_c = bus.idx_dd[IDX_RSVD_BIT];

  always_comb begin
    pending_d  = pending_q;
    idx_d      = '0;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    ops_d      = ops_q;
    ret_mask_c = '0;

    if (rsp_valid_c) ret_mask_c[ret_id_c] = 1'b1;
    pending_d = (pending_q & ~ret_mask_c) | arb_gnt_c;

    if (arb_vld_c) begin
      idx_d    = make_idx(arb_id_c);
      data_a_d = get_slot(bus.req_dataA, arb_id_c);
      data_b_d = get_slot(bus.req_dataB, arb_id_c);
    end

    if (rsp_valid_c && (ops_q != CNT_W'(OPS_MAX))) ops_d = ops_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pending_q <= '0;
      idx_q     <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      ops_q     <= '0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      ops_q     <= ops_d;
    end
  end

  // Grant is forced low while reset is held
  assign bus.gnt       = reset_L ? arb_gnt_c : '0;
  assign bus.idx       = idx_q;
  assign bus.dataA     = data_a_q;
  assign bus.dataB     = data_b_q;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_id    = ret_id_c;
  assign bus.rsp_sum   = bus.sum30_dd;
  assign bus.ops_done  = ops_q;

endmodule

// File: doc/arbitro_sumador.md
ARBITRO_SUMADOR -- requirements
Module: arbitro_sumador

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately on reset_L low, independent of clk.
REQ-002 clk  input  1  rising-edge clock shared with the pipelined adder.
REQ-003 reset_L  input  1  asynchronous active-low reset.
REQ-004 req  input  4  per-requester request, bit i = requester i, held until granted.
REQ-005 req_dataA  input  16  operand A, requester i on bits [4i+3:4i].
REQ-006 req_dataB  input  16  operand B, same packing as req_dataA.
REQ-007 gnt  output  4  one-hot grant, combinational, at most one bit high per cycle.
REQ-008 idx  output  4  tag to adder, registered: {valid, 0, id[1:0]}.
REQ-009 dataA, dataB  output  4 each  registered operands to adder.
REQ-010 idx_dd, sum30_dd  input  4 each  tag and sum returned by adder, 2 cycles after idx.
REQ-011 rsp_valid  output  1  combinational, result for rsp_id present this cycle.
REQ-012 rsp_id  output  2  requester owning result (idx_dd[1:0]).
REQ-013 rsp_sum  output  4  result (sum30_dd).
REQ-014 ops_done  output  8  registered count of delivered responses.

Function
REQ-015 Eligible set SHALL be req & ~pending; gnt SHALL select one eligible requester per cycle per the arbitration policy (REQ-026/027).
REQ-016 At the edge where gnt[i]=1: idx<={1,0,i}, dataA/dataB<=operands of i, pending[i]<=1, last<=i.
REQ-017 With no eligible requester, idx SHALL register 4'b0000 (bubble); dataA/dataB SHALL hold previous values.
REQ-018 Issue throughput SHALL be one operation per cycle; no requester SHALL have more than one op in flight.
REQ-019 rsp_valid SHALL equal idx_dd[3] & pending[idx_dd[1:0]]; rsp_id=idx_dd[1:0]; rsp_sum=sum30_dd; adder sum width 4 bits, carry discarded (wrap modulo 16).
REQ-020 On rsp_valid, pending[rsp_id] SHALL clear at that edge; the requester SHALL become eligible the following cycle, not the same cycle.
REQ-021 Request-to-response latency SHALL be 3 cycles from the grant edge (1 controller register + 2 adder stages); rsp_valid SHALL be a 1-cycle pulse.
REQ-022 ops_done SHALL increment on each rsp_valid and saturate at 255.
REQ-023 Grant and return for different requesters in the same cycle SHALL both take effect.
REQ-024 A requester dropping req before grant SHALL simply lose eligibility; no state change.

Reset
REQ-025 On reset_L low: gnt=0, idx=0, dataA=0, dataB=0, pending=0, last=3, ops_done=0; responses arriving with pending=0 (flushed in-flight ops) SHALL be suppressed.

Configuration
REQ-026 With SUMARB_ROUNDROBIN_EN defined: search SHALL start at last+1 mod 4, so after reset requester 0 has highest priority.
REQ-027 Without SUMARB_ROUNDROBIN_EN: fixed priority, requester 0 highest, 3 lowest; last register SHALL be omitted.

Structure
REQ-028 Shared package SHALL hold NUM_REQ=4, DATA_W=4, ID_W=2, ADDER_LAT=2 and the idx tag field positions.
REQ-029 Arbitration (eligible in, one-hot gnt out, last pointer) SHALL be one sub-module, rr_arbitro4.

Verification
REQ-030 Single req[0], A=3, B=4 -> gnt=0001 one cycle; 3 cycles later rsp_valid=1, rsp_id=0, rsp_sum=7; ops_done=1.
REQ-031 req=1111 held continuously, round robin -> grant order 0,1,2,3, then stall until req0 response clears pending, then 0 resumes; without macro, 0 re-granted as soon as eligible.
REQ-032 Overflow: A=9, B=8 -> rsp_sum=1.
REQ-033 reset_L low 1 cycle after grant (asynchronous, mid-cycle) -> no rsp_valid afterward, ops_done=0, pending=0.
REQ-034 300 back-to-back ops -> ops_done stops at 255.
REQ-035 Same-cycle return of id 1 and grant to id 2 -> both occur; id 1 not granted until next cycle.
